rx_ip_dispatch: RTL and testbench

Receive-side IPv4 payload dispatcher, placed directly after the IPv4 header parser on the RX_CLK domain. It takes the parser's payload byte stream and header fields, trims Ethernet padding and FCS using the IPv4 total length, and routes each datagram to one of three protocol consumers (UDP, ICMP, TCP). Disabled, unknown or malformed datagrams are discarded and counted. The parser's received-payload path is shared between consumers, and this block arbitrates it per datagram.

---
 rtl/rx_ip_dispatch_if.sv | 24 ++
 rtl/rx_ip_dispatch.sv | 160 ++++++++++++++++
 tb/tb_rx_ip_dispatch.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/rx_ip_dispatch_if.sv
// rx_ip_dispatch_if: parser-side payload stream plus the shared routed-byte bus.
// The master side is the IPv4 parser and the consumers. The slave side is the dispatcher.
interface rx_ip_dispatch_if #(
  parameter int OCT = 8
);
  logic [3:0]       rx_header_len;
  logic [2*OCT-1:0] rx_total_len;
  logic [OCT-1:0]   rx_protocol;
  logic             rx_ipv4_data_v;
  logic [OCT-1:0]   rx_ipv4_data;
  logic [OCT-1:0]   out_data;
  logic [2:0]       out_v;
  logic             out_last;

  modport master (
    output rx_header_len, rx_total_len, rx_protocol, rx_ipv4_data_v, rx_ipv4_data,
    input  out_data, out_v, out_last
  );

  modport slave (
    input  rx_header_len, rx_total_len, rx_protocol, rx_ipv4_data_v, rx_ipv4_data,
    output out_data, out_v, out_last
  );
endinterface

// File: rtl/rx_ip_dispatch.sv
// rx_ip_dispatch: trims IPv4 padding/FCS and routes each datagram's payload
// to the UDP, ICMP or TCP consumer lane. Datagrams that are malformed, truncated,
// unknown or disabled are discarded and counted.
// Optional build macro RX_IP_DISPATCH_STATS_EN adds per-destination delivery
// counters udp_cnt, icmp_cnt and tcp_cnt.
module rx_ip_dispatch #(
  parameter int             OCT   = 8,
  parameter int             CNT_W = 16,
  parameter logic [OCT-1:0] UDP   = 8'h11,
  parameter logic [OCT-1:0] ICMP  = 8'h01,
  parameter logic [OCT-1:0] TCP   = 8'h06
) (
  input  logic             RX_CLK,
  input  logic             rst,
  input  logic             func_en,
  input  logic [2:0]       route_en,
  rx_ip_dispatch_if.slave  bus,
  output logic             dispatch_irq,
  output logic             len_err,
  output logic [CNT_W-1:0] drop_cnt
`ifdef RX_IP_DISPATCH_STATS_EN
  ,
  output logic [CNT_W-1:0] udp_cnt,
  output logic [CNT_W-1:0] icmp_cnt,
  output logic [CNT_W-1:0] tcp_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, PASS, PAD, DROP} state_t;

  state_t           state;
  logic             data_vp;
  logic             rst_hold;   // set by reset, cleared once data_v is seen low
  logic [2*OCT-1:0] byte_cnt;   // payload bytes still to forward after the current one
  logic [1:0]       dest;
  logic             irq_pend;   // delays dispatch_irq by one cycle after out_last

  logic [2*OCT-1:0] hdr_bytes;
  logic [2*OCT-1:0] pay_len;
  logic             hdr_bad;
  logic [1:0]       proto_idx;
  logic             route_hit;
  logic             start;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Decode the header fields presented with the start beat.
  always_comb begin
    hdr_bytes = {{(2*OCT-6){1'b0}}, bus.rx_header_len, 2'b00};
    pay_len   = bus.rx_total_len - hdr_bytes;
    hdr_bad   = (bus.rx_header_len < 4'd5) || (bus.rx_total_len < hdr_bytes) ||
                (pay_len == '0);
    proto_idx = 2'd0;
    route_hit = 1'b0;
    case (bus.rx_protocol)
      UDP:     begin proto_idx = 2'd0; route_hit = route_en[0]; end
      ICMP:    begin proto_idx = 2'd1; route_hit = route_en[1]; end
      TCP:     begin proto_idx = 2'd2; route_hit = route_en[2]; end
      default: begin proto_idx = 2'd0; route_hit = 1'b0;        end
    endcase
    // A rising edge of data_v starts a datagram. After a reset, the block waits
    // for data_v to go low, so the tail of an aborted datagram is not taken as a new one.
    start = (state == IDLE) && bus.rx_ipv4_data_v && !data_vp && !rst_hold;
  end

  // Dispatch FSM. It drives the registered stream outputs, pulses and counters.
  always_ff @(posedge RX_CLK) begin
    if (rst) begin
      state         <= IDLE;
      data_vp       <= 1'b0;
      rst_hold      <= 1'b1;
      byte_cnt      <= '0;
      dest          <= 2'd0;
      irq_pend      <= 1'b0;
      bus.out_data  <= '0;
      bus.out_v     <= '0;
      bus.out_last  <= 1'b0;
      dispatch_irq  <= 1'b0;
      len_err       <= 1'b0;
      drop_cnt      <= '0;
`ifdef RX_IP_DISPATCH_STATS_EN
      udp_cnt       <= '0;
      icmp_cnt      <= '0;
      tcp_cnt       <= '0;
`endif
    end else if (!func_en) begin
      bus.out_v     <= '0;
      bus.out_last  <= 1'b0;
      dispatch_irq  <= 1'b0;
      len_err       <= 1'b0;
    end else begin
      data_vp       <= bus.rx_ipv4_data_v;
      if (!bus.rx_ipv4_data_v) rst_hold <= 1'b0;
      bus.out_v     <= '0;
      bus.out_last  <= 1'b0;
      len_err       <= 1'b0;
      dispatch_irq  <= irq_pend;
      irq_pend      <= 1'b0;
`ifdef RX_IP_DISPATCH_STATS_EN
      if (irq_pend) begin
        case (dest)
          2'd0:    udp_cnt  <= sat_inc(udp_cnt);
          2'd1:    icmp_cnt <= sat_inc(icmp_cnt);
          default: tcp_cnt  <= sat_inc(tcp_cnt);
        endcase
      end
`endif
      case (state)
        IDLE: begin
          if (start) begin
            if (hdr_bad) begin
              len_err  <= 1'b1;
              drop_cnt <= sat_inc(drop_cnt);
              state    <= DROP;
            end else if (!route_hit) begin
              drop_cnt <= sat_inc(drop_cnt);
              state    <= DROP;
            end else begin
              dest         <= proto_idx;
              byte_cnt     <= pay_len - 1'b1;
              bus.out_data <= bus.rx_ipv4_data;
              bus.out_v    <= 3'b001 << proto_idx;
              if (pay_len == 1) begin
                bus.out_last <= 1'b1;
                irq_pend     <= 1'b1;
                state        <= PAD;
              end else begin
                state <= PASS;
              end
            end
          end
        end
        PASS: begin
          if (bus.rx_ipv4_data_v) begin
            bus.out_data <= bus.rx_ipv4_data;
            bus.out_v    <= 3'b001 << dest;
            byte_cnt     <= byte_cnt - 1'b1;
            if (byte_cnt == 1) begin
              bus.out_last <= 1'b1;
              irq_pend     <= 1'b1;
              state        <= PAD;
            end
          end else begin
            // data_v fell before the payload was complete. The bytes already sent stay sent.
            len_err  <= 1'b1;
            drop_cnt <= sat_inc(drop_cnt);
            state    <= IDLE;
          end
        end
        PAD, DROP: begin
          if (!bus.rx_ipv4_data_v) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_ip_dispatch.sv
// tb_rx_ip_dispatch: directed and randomized datagrams for rx_ip_dispatch. Each
// datagram's expected lane bytes, pulses and drop count come from a per-datagram
// reference model.
module tb_rx_ip_dispatch;
  logic        RX_CLK = 1'b0;
  logic        rst;
  logic        func_en;
  logic [2:0]  route_en;
  logic        dispatch_irq;
  logic        len_err;
  logic [15:0] drop_cnt;
`ifdef RX_IP_DISPATCH_STATS_EN
  logic [15:0] udp_cnt, icmp_cnt, tcp_cnt;
`endif

  rx_ip_dispatch_if #(.OCT(8)) bus ();

  rx_ip_dispatch dut (
    .RX_CLK       (RX_CLK),
    .rst          (rst),
    .func_en      (func_en),
    .route_en     (route_en),
    .bus          (bus),
    .dispatch_irq (dispatch_irq),
    .len_err      (len_err),
    .drop_cnt     (drop_cnt)
`ifdef RX_IP_DISPATCH_STATS_EN
    ,
    .udp_cnt      (udp_cnt),
    .icmp_cnt     (icmp_cnt),
    .tcp_cnt      (tcp_cnt)
`endif
  );

  always #5 RX_CLK = ~RX_CLK;

  int cyc = 0;
  always @(posedge RX_CLK) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] cyc;
    logic [2:0]  lane;
    logic        last;
    logic [7:0]  data;
  } beat_t;

  beat_t obs_b[$], exp_b[$];
  int    obs_irq[$], exp_irq[$], obs_err[$], exp_err[$];
  int    exp_drop = 0;
  bit    mon_en = 0;
  int    checks = 0, failures = 0;

  // Log every lane beat and pulse, together with the edge that produced it.
  always @(negedge RX_CLK) begin
    if (mon_en) begin
      if (bus.out_v != 3'b000 || bus.out_last)
        obs_b.push_back('{32'(cyc), bus.out_v, bus.out_last, bus.out_data});
      if (dispatch_irq) obs_irq.push_back(cyc);
      if (len_err)      obs_err.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge RX_CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      step();
      bus.rx_ipv4_data_v = 1'b0;
    end
  endtask

  // Drive one datagram of nb beats followed by a single low cycle. If gap >= 0,
  // func_en drops for 3 cycles while beat 'gap' is held on the bus.
  // The reference expectations are then appended.
  task automatic send(input logic [7:0] proto, input int ihl, input int tlen,
                      input logic [2:0] ren, input int nb, input int gap);
    int         be[$];
    logic [7:0] pl[$];
    int         lowe, L, lane, n;
    bit         bad;
    for (int i = 0; i < nb; i++) begin
      step();
      bus.rx_ipv4_data_v = 1'b1;
      bus.rx_ipv4_data   = 8'($urandom);
      if (i == 0) begin
        bus.rx_protocol   = proto;
        bus.rx_header_len = 4'(ihl);
        bus.rx_total_len  = 16'(tlen);
        route_en          = ren;
      end else begin
        bus.rx_protocol   = 8'($urandom);
        bus.rx_header_len = 4'($urandom);
        bus.rx_total_len  = 16'($urandom);
        route_en          = 3'($urandom);
      end
      if (i == gap) begin
        func_en = 1'b0;
        repeat (3) step();
        func_en = 1'b1;
      end
      be.push_back(cyc + 1);
      pl.push_back(bus.rx_ipv4_data);
    end
    step();
    bus.rx_ipv4_data_v = 1'b0;
    lowe = cyc + 1;

    L    = tlen - 4 * ihl;
    bad  = (ihl < 5) || (tlen < 4 * ihl) || (L == 0);
    lane = (proto == 8'h11) ? 0 : (proto == 8'h01) ? 1 : (proto == 8'h06) ? 2 : -1;
    if (bad) begin
      exp_err.push_back(be[0]);
      exp_drop++;
    end else if (lane < 0) begin
      exp_drop++;
    end else if (!ren[lane]) begin
      exp_drop++;
    end else begin
      n = (nb < L) ? nb : L;
      for (int i = 0; i < n; i++)
        exp_b.push_back('{32'(be[i]), 3'(1 << lane), (i == L - 1), pl[i]});
      if (nb >= L) exp_irq.push_back(be[L-1] + 1);
      else begin
        exp_err.push_back(lowe);
        exp_drop++;
      end
    end
  endtask

  task automatic check(input string tag);
    chk({tag, ":beats"}, 64'(obs_b.size()), 64'(exp_b.size()));
    for (int i = 0; i < obs_b.size() && i < exp_b.size(); i++)
      chk({tag, ":beat"}, 64'(obs_b[i]), 64'(exp_b[i]));
    chk({tag, ":irqs"}, 64'(obs_irq.size()), 64'(exp_irq.size()));
    for (int i = 0; i < obs_irq.size() && i < exp_irq.size(); i++)
      chk({tag, ":irq_cyc"}, 64'(obs_irq[i]), 64'(exp_irq[i]));
    chk({tag, ":errs"}, 64'(obs_err.size()), 64'(exp_err.size()));
    for (int i = 0; i < obs_err.size() && i < exp_err.size(); i++)
      chk({tag, ":err_cyc"}, 64'(obs_err[i]), 64'(exp_err[i]));
    chk({tag, ":drop_cnt"}, 64'(drop_cnt), 64'(exp_drop));
    obs_b.delete(); exp_b.delete();
    obs_irq.delete(); exp_irq.delete();
    obs_err.delete(); exp_err.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ":out_v"}, 64'(bus.out_v), 64'd0);
    chk({tag, ":out_last"}, 64'(bus.out_last), 64'd0);
    chk({tag, ":out_data"}, 64'(bus.out_data), 64'd0);
    chk({tag, ":irq"}, 64'(dispatch_irq), 64'd0);
    chk({tag, ":len_err"}, 64'(len_err), 64'd0);
    chk({tag, ":drop_cnt"}, 64'(drop_cnt), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pr;
    int         ihl, tlen, L, nb;
    rst = 1'b1; func_en = 1'b1; route_en = 3'b000;
    bus.rx_ipv4_data_v = 1'b0; bus.rx_ipv4_data = 8'h00;
    bus.rx_protocol = 8'h00; bus.rx_header_len = 4'h0; bus.rx_total_len = 16'h0000;
    repeat (3) step();
    rst = 1'b0;
    @(negedge RX_CLK);
    chk_zero("reset");
    mon_en = 1;
    idle(2);

    send(8'h11, 5, 16'h001C, 3'b111, 30, -1); idle(4); check("udp_basic");
    send(8'h01, 5, 16'h0054, 3'b101, 70, -1); idle(3); check("icmp_disabled");
    send(8'h11, 4, 16'h0028, 3'b111, 12, -1); idle(3); check("ihl4");
    send(8'h06, 5, 16'h0010, 3'b111, 10, -1); idle(3); check("tlen_short");
    send(8'h06, 5, 16'h0064, 3'b111, 50, -1); idle(3); check("tcp_trunc");
    send(8'h11, 5, 16'h001C, 3'b111, 10, -1);
    send(8'h06, 5, 16'h0028, 3'b111, 26, -1); idle(4); check("back_to_back");
    send(8'h11, 5, 16'h0015, 3'b111, 3, -1);  idle(4); check("len_one");
    send(8'h11, 5, 16'h0028, 3'b111, 24, 6);  idle(4); check("func_gap");

    // Reset in the middle of a datagram. The rest of that datagram must be ignored.
    mon_en = 0;
    step();
    bus.rx_ipv4_data_v = 1'b1; bus.rx_ipv4_data = 8'($urandom);
    bus.rx_protocol = 8'h11; bus.rx_header_len = 4'd5; bus.rx_total_len = 16'd60;
    route_en = 3'b111;
    repeat (4) begin step(); bus.rx_ipv4_data = 8'($urandom); end
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    @(negedge RX_CLK);
    chk_zero("mid_reset");
    exp_drop = 0;
    mon_en = 1;
    repeat (8) begin step(); bus.rx_ipv4_data = 8'($urandom); end
    idle(3); check("reset_tail");
    send(8'h11, 5, 16'd34, 3'b111, 16, -1); idle(4); check("post_reset");

    for (int k = 0; k < 30; k++) begin
      case ($urandom_range(0, 3))
        0:       pr = 8'h11;
        1:       pr = 8'h01;
        2:       pr = 8'h06;
        default: pr = 8'($urandom);
      endcase
      ihl = $urandom_range(3, 7);
      if ($urandom_range(0, 5) == 0) tlen = $urandom_range(0, 4 * ihl);
      else                           tlen = 4 * ihl + $urandom_range(0, 40);
      L  = tlen - 4 * ihl;
      nb = (L > 0) ? $urandom_range(1, L + 6) : $urandom_range(1, 6);
      send(pr, ihl, tlen, 3'($urandom), nb, -1);
      idle($urandom_range(1, 3));
      idle(3);
      check("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
